axi_burst_reader: RTL
=====================

AXI_BURST_READER -- requirements
Module: axi_burst_reader

Interface
REQ-001 Parameter MAX_BURST, 16, maximum beats per AR burst (1..256).
REQ-002 Parameter FIFO_DEPTH, 16, output buffer entries of 64 bits; SHALL be >= MAX_BURST.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  transfer-command handshake.
REQ-006 cmd_addr  in  64  start byte address; bits [2:0] ignored and treated as 0.
REQ-007 cmd_beats  in  16  number of 64-bit beats to fetch.
REQ-008 ar_valid/ar_ready  out/in  1/1  read-address handshake to the memory slave.
REQ-009 ar_addr  out  64,  ar_len  out  8,  ar_size  out  3,  ar_burst  out  2  are the burst attributes.
REQ-010 r_valid/r_ready  in/out  1/1,  r_data  in  64,  r_resp  in  2,  r_last  in  1  form the read-data channel.
REQ-011 out_valid/out_ready  out/in  1/1,  out_data  out  64  form the pixel-word stream to the encoder.
REQ-012 busy  out  1  is high while a command is in progress.
REQ-013 done  out  1  is a one-cycle pulse marking command completion.
REQ-014 err  out  1  is a sticky error flag.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, and DATA, with one outstanding burst at a time.
REQ-016 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready the block SHALL latch addr, set remaining=cmd_beats, and clear err.
REQ-017 cmd_beats==0 SHALL produce no AR; done SHALL pulse the next cycle and the FSM SHALL remain in IDLE.
REQ-018 Burst beats SHALL be len=min(remaining, MAX_BURST, (4096-addr[11:0])>>3); no burst SHALL cross a 4 KB boundary.
REQ-019 IDLE->ADDR (command accepted, beats>0), then ADDR SHALL hold ar_valid low until FIFO free entries >= len, then assert it.
REQ-020 While ar_valid is high, ar_addr/ar_len/ar_size/ar_burst SHALL be stable.
REQ-021 ar_len SHALL equal len-1, ar_size SHALL equal 3'b011, and ar_burst SHALL equal 2'b01 (INCR).
REQ-022 ar_valid&&ar_ready SHALL cause ADDR->DATA, beat counter=0, addr+=len*8, and remaining-=len.
REQ-023 In DATA, r_ready SHALL be 1; each r_valid&&r_ready SHALL push r_data into the FIFO and increment the beat counter.
REQ-024 The burst SHALL end on the beat where counter==len-1; the FSM SHALL then go to ADDR if remaining>0, else to IDLE with done pulsing in that same transition cycle.
REQ-025 r_resp!=0 on any accepted beat SHALL set err; the data SHALL still be pushed and the transfer SHALL continue.
REQ-026 An r_last mismatch SHALL set err: r_last asserted on a non-final beat, or deasserted on the final beat.
REQ-027 err SHALL remain set until the next command is accepted.
REQ-028 The FIFO SHALL be first-word-fall-through: out_valid=!empty, out_data=head, and a pop occurs on out_valid&&out_ready.
REQ-029 Simultaneous push and pop SHALL leave the count unchanged.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 The credit check SHALL count committed-but-unreceived beats, so a push never occurs when the FIFO is full.
REQ-032 busy SHALL be (state!=IDLE) || out_valid; a new command MAY be accepted while the FIFO still drains.
REQ-033 Address arithmetic SHALL be 64-bit and wrap modulo 2^64 with no error.
REQ-034 No combinational path SHALL exist from ar_ready or r_valid to ar_valid.

Reset
REQ-035 On reset the FSM SHALL be IDLE and the FIFO SHALL be emptied.
REQ-036 After reset, the outputs SHALL be: cmd_ready=1, ar_valid=0, ar_addr=0, ar_len=0, ar_size=3'b011, ar_burst=2'b01, r_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0.
REQ-037 Reset mid-burst SHALL abandon the transfer with no done pulse; the environment SHALL reset the slave in the same cycle.

Verification
REQ-038 cmd_addr=0x1000, cmd_beats=40, out_ready=1 -> three bursts: ar_addr=0x1000/0x1080/0x1100 with ar_len=15/15/7; 40 words in address order; a single done pulse.
REQ-039 cmd_addr=0x0FF0, cmd_beats=4 -> bursts 0x0FF0 ar_len=1 and 0x1000 ar_len=1; 4 words out.
REQ-040 cmd_beats=0 -> no ar_valid; done high exactly one cycle after acceptance; err=0.
REQ-041 cmd_beats=32, out_ready=0 -> the first burst fills the FIFO (16 entries) and the second ar_valid stays low; raising out_ready releases the second burst; all 32 words delivered with no loss.
REQ-042 r_resp=2'b10 on beat 3 of 8 -> err=1 after that beat, all 8 words delivered, done pulses, err clears on the next cmd accept.
REQ-043 Assert reset during DATA of a 16-beat burst -> the next cycle shows IDLE, out_valid=0, and no done pulse; a new command then completes normally.

Source files
------------

// File: rtl/axi_burst_reader.sv
// AXI4 read burst engine: splits a beat-count command into 4 KB-safe
// INCR bursts and streams the returned words through a FWFT buffer.
module axi_burst_reader #(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_addr,
  input  logic [15:0] cmd_beats,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [63:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [63:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;

  logic [63:0]   addr;
  logic [15:0]   remaining;
  logic [8:0]    burst_len;
  logic [8:0]    beat;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [12:0]   page_room;
  logic [16:0]   len;
  logic          credit_ok;
  logic          cmd_fire;
  logic          ar_fire;
  logic          push;
  logic          pop;
  logic          last_beat;

  // Next burst size: bounded by work left, burst cap and the 4 KB page.
  assign page_room = 13'd4096 - {1'b0, addr[11:0]};
  always_comb begin
    len = {1'b0, remaining};
    if (len > 17'(MAX_BURST)) len = 17'(MAX_BURST);
    if (len > 17'(page_room >> 3)) len = 17'(page_room >> 3);
  end

  // Only one burst is ever outstanding, so in ADDR nothing is in flight.
  assign credit_ok = (17'(FIFO_DEPTH) - 17'(count)) >= len;

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_beats != 16'd0) state_nx = ADDR;
      end
      ADDR: begin
        ar_valid = credit_ok;
        if (credit_ok && ar_ready) state_nx = DATA;
      end
      DATA: begin
        r_ready = 1'b1;
        if (r_valid && last_beat)
          state_nx = (remaining != 16'd0) ? ADDR : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign ar_fire   = ar_valid && ar_ready;
  assign push      = r_valid && r_ready;
  assign pop       = out_valid && out_ready;
  assign last_beat = beat == burst_len - 9'd1;

  assign ar_addr  = addr;
  assign ar_len   = (len == 17'd0) ? 8'd0 : 8'(len - 17'd1);
  assign ar_size  = 3'b011;
  assign ar_burst = 2'b01;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      burst_len <= '0;
      beat      <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (cmd_fire) begin
        addr      <= cmd_addr & ~64'h7;
        remaining <= cmd_beats;
        err       <= 1'b0;
        if (cmd_beats == 16'd0) done <= 1'b1;
      end
      if (ar_fire) begin
        addr      <= addr + {44'd0, len, 3'b000};
        remaining <= remaining - len[15:0];
        burst_len <= len[8:0];
        beat      <= '0;
      end
      if (push) begin
        beat <= beat + 9'd1;
        if (r_resp != 2'b00 || r_last != last_beat) err <= 1'b1;
        if (last_beat && remaining == 16'd0) done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= r_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid = count != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE) || out_valid;
endmodule
